pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Request/flush bus between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int STAGES = 6,
   parameter int NREQ   = 4,
   parameter int SW     = 3
);
   logic [NREQ-1:0]    stallreq;
   logic [NREQ*SW-1:0] stallreq_stage;
   logic               excp_valid;
   logic [31:0]        excp_pc;
   logic [STAGES-1:0]  stall;
   logic [STAGES-1:0]  bubble;
   logic               flush;
   logic [31:0]        new_pc;
   logic               stall_timeout;
   logic [31:0]        perf_stall_cnt;
   logic [31:0]        perf_flush_cnt;

   modport master (
      output stallreq, stallreq_stage, excp_valid, excp_pc,
      input  stall, bubble, flush, new_pc, stall_timeout, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  stallreq, stallreq_stage, excp_valid, excp_pc,
      output stall, bubble, flush, new_pc, stall_timeout, perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, one-cycle exception flush, stall watchdog.
// Optional performance counters are built when CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter int STAGES = 6,
   parameter int NREQ   = 4,
   parameter int SW     = 3,
   parameter int WDOG   = 1024
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [SW:0] STAGE_LIM = (SW+1)'(STAGES);
   localparam logic [SW:0] ONE_K     = {{SW{1'b0}}, 1'b1};
   // Timeout is raised on the edge where the run length becomes WDOG-1.
   localparam logic [15:0] WDOG_TRIP = 16'(WDOG - 2);

   state_t            state_r;
   state_t            state_nxt_s;
   logic              flush_s;
   logic              take_s;
   logic              any_s;
   logic [SW-1:0]     max_k_s;
   logic [SW-1:0]     k_s;
   logic [STAGES-1:0] stall_s;
   logic [STAGES-1:0] bubble_s;
   logic [31:0]       new_pc_r;
   logic [15:0]       wdog_r;
   logic              timeout_r;

   // Deepest valid stage among all active stall requests
   always_comb begin
      any_s   = 1'b0;
      max_k_s = {SW{1'b0}};
      k_s     = {SW{1'b0}};
      for (int r = 0; r < NREQ; r++) begin
         k_s = bus.stallreq_stage[r*SW +: SW];
         if (bus.stallreq[r] && ({1'b0, k_s} < STAGE_LIM) && (!any_s || (k_s > max_k_s))) begin
            any_s   = 1'b1;
            max_k_s = k_s;
         end else begin
            any_s   = any_s;
            max_k_s = max_k_s;
         end
      end
   end

   // FSM next state plus stall/bubble shaping
   always_comb begin
      state_nxt_s = state_r;
      flush_s     = 1'b0;
      take_s      = 1'b0;
      stall_s     = {STAGES{1'b0}};
      bubble_s    = {STAGES{1'b0}};
      case (state_r)
         IDLE: begin
            if (bus.excp_valid) begin
               state_nxt_s = FLUSH;
               take_s      = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
            for (int i = 0; i < STAGES; i++) begin
               stall_s[i]  = any_s && ((SW+1)'(i) <= {1'b0, max_k_s});
               bubble_s[i] = any_s && ((SW+1)'(i) == ({1'b0, max_k_s} + ONE_K));
            end
         end
         FLUSH: begin
            state_nxt_s = IDLE;
            flush_s     = 1'b1;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      if (rst) begin
         stall_s  = {STAGES{1'b0}};
         bubble_s = {STAGES{1'b0}};
         take_s   = 1'b0;
      end else begin
         take_s   = take_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Redirect target captured on flush entry
   always_ff @(posedge clk) begin
      if (rst) begin
         new_pc_r <= 32'd0;
      end else if (take_s) begin
         new_pc_r <= bus.excp_pc;
      end else begin
         new_pc_r <= new_pc_r;
      end
   end

   // Stall watchdog: saturating run-length counter and sticky timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_r    <= 16'd0;
         timeout_r <= 1'b0;
      end else if (stall_s == {STAGES{1'b0}}) begin
         wdog_r    <= 16'd0;
         timeout_r <= timeout_r;
      end else begin
         wdog_r    <= (wdog_r == 16'hFFFF) ? wdog_r : (wdog_r + 16'd1);
         timeout_r <= timeout_r | (wdog_r >= WDOG_TRIP);
      end
   end

`ifdef CTRL_PERF_EN
   logic [31:0] perf_stall_r;
   logic [31:0] perf_flush_r;

   // Performance counters, free-running modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_r <= 32'd0;
         perf_flush_r <= 32'd0;
      end else begin
         perf_stall_r <= perf_stall_r + ((stall_s != {STAGES{1'b0}}) ? 32'd1 : 32'd0);
         perf_flush_r <= perf_flush_r + (take_s ? 32'd1 : 32'd0);
      end
   end

   assign bus.perf_stall_cnt = perf_stall_r;
   assign bus.perf_flush_cnt = perf_flush_r;
`else
   assign bus.perf_stall_cnt = 32'd0;
   assign bus.perf_flush_cnt = 32'd0;
`endif

   assign bus.stall         = stall_s;
   assign bus.bubble        = bubble_s;
   assign bus.flush         = flush_s;
   assign bus.new_pc        = new_pc_r;
   assign bus.stall_timeout = timeout_r;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
   localparam int STAGES = 6;
   localparam int NREQ   = 4;
   localparam int SW     = 3;
   localparam int WDOG   = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.STAGES(STAGES), .NREQ(NREQ), .SW(SW)) bus();

   pipe_ctrl #(.STAGES(STAGES), .NREQ(NREQ), .SW(SW), .WDOG(WDOG)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   bit                m_flush;
   logic [31:0]       m_pc;
   int                m_run;
   bit                m_to;
   logic [31:0]       m_pstall;
   logic [31:0]       m_pflush;
   logic [STAGES-1:0] e_stall;
   logic [STAGES-1:0] e_bubble;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_merge();
      int maxk;
      int k;
      maxk = -1;
      for (int r = 0; r < NREQ; r++) begin
         k = int'(bus.stallreq_stage[r*SW +: SW]);
         if (bus.stallreq[r] && k < STAGES && k > maxk) maxk = k;
      end
      e_stall  = '0;
      e_bubble = '0;
      if (!rst && !m_flush && maxk >= 0) begin
         e_stall = STAGES'((1 << (maxk + 1)) - 1);
         if (maxk + 1 < STAGES) e_bubble = STAGES'(1 << (maxk + 1));
      end
   endtask

   task automatic drive(input logic [3:0] sr, input logic [11:0] stg, input logic ev,
                        input logic [31:0] pc, input logic r);
      @(negedge clk);
      bus.stallreq       = sr;
      bus.stallreq_stage = stg;
      bus.excp_valid     = ev;
      bus.excp_pc        = pc;
      rst                = r;
      #1;
      expect_merge();
   endtask

   task automatic check_all();
      chk("stall", 32'(bus.stall), 32'(e_stall));
      chk("bubble", 32'(bus.bubble), 32'(e_bubble));
      chk("flush", 32'(bus.flush), 32'(m_flush));
      chk("new_pc", bus.new_pc, m_pc);
      chk("timeout", 32'(bus.stall_timeout), 32'(m_to));
`ifdef CTRL_PERF_EN
      chk("perf_stall", bus.perf_stall_cnt, m_pstall);
      chk("perf_flush", bus.perf_flush_cnt, m_pflush);
`else
      chk("perf_stall", bus.perf_stall_cnt, 32'd0);
      chk("perf_flush", bus.perf_flush_cnt, 32'd0);
`endif
   endtask

   task automatic advance();
      if (rst) begin
         m_flush = 0; m_pc = 32'd0; m_run = 0; m_to = 0; m_pstall = 32'd0; m_pflush = 32'd0;
      end else begin
         if (e_stall != '0) begin
            m_run++;
            m_pstall++;
            if (m_run >= WDOG - 1) m_to = 1;
         end else begin
            m_run = 0;
         end
         if (!m_flush && bus.excp_valid) begin
            m_flush = 1;
            m_pc    = bus.excp_pc;
            m_pflush++;
         end else begin
            m_flush = 0;
         end
      end
      @(posedge clk);
   endtask

   task automatic step(input logic [3:0] sr, input logic [11:0] stg, input logic ev,
                       input logic [31:0] pc, input logic r);
      drive(sr, stg, ev, pc, r);
      check_all();
      advance();
   endtask

   initial begin
      logic [31:0] exp_pf;
      // power-up reset
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b1); advance();
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b1); advance();
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_new_pc", bus.new_pc, 32'd0);
      chk("rst_timeout", 32'(bus.stall_timeout), 32'd0);
      check_all(); advance();

      // single request at ID
      drive(4'b0001, 12'o0002, 1'b0, 32'd0, 1'b0);
      chk("merge_id_stall", 32'(bus.stall), 32'h07);
      chk("merge_id_bubble", 32'(bus.bubble), 32'h08);
      chk("merge_id_flush", 32'(bus.flush), 32'd0);
      check_all(); advance();

      // two requests, deepest wins
      drive(4'b0011, 12'o0031, 1'b0, 32'd0, 1'b0);
      chk("merge_max_stall", 32'(bus.stall), 32'h0F);
      chk("merge_max_bubble", 32'(bus.bubble), 32'h10);
      check_all(); advance();

      // out-of-range stage ignored
      drive(4'b0001, 12'o0007, 1'b0, 32'd0, 1'b0);
      chk("merge_oor_stall", 32'(bus.stall), 32'd0);
      chk("merge_oor_bubble", 32'(bus.bubble), 32'd0);
      check_all(); advance();

      // exception with concurrent stall
      drive(4'b0001, 12'o0002, 1'b1, 32'hBFC00380, 1'b0);
      chk("excp_stall_same", 32'(bus.stall), 32'h07);
      check_all(); advance();
      drive(4'b0001, 12'o0002, 1'b0, 32'd0, 1'b0);
      chk("excp_flush", 32'(bus.flush), 32'd1);
      chk("excp_new_pc", bus.new_pc, 32'hBFC00380);
      chk("excp_stall_forced", 32'(bus.stall), 32'd0);
      check_all(); advance();
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      chk("excp_flush_end", 32'(bus.flush), 32'd0);
      check_all(); advance();

      // excp_valid held two cycles -> single flush
      step(4'd0, 12'd0, 1'b0, 32'd0, 1'b1);
      step(4'd0, 12'd0, 1'b1, 32'h80000180, 1'b0);
      drive(4'd0, 12'd0, 1'b1, 32'h12345678, 1'b0);
      chk("b2b_flush", 32'(bus.flush), 32'd1);
      check_all(); advance();
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      chk("b2b_flush_once", 32'(bus.flush), 32'd0);
      chk("b2b_pc_kept", bus.new_pc, 32'h80000180);
`ifdef CTRL_PERF_EN
      exp_pf = 32'd1;
`else
      exp_pf = 32'd0;
`endif
      chk("b2b_perf_flush", bus.perf_flush_cnt, exp_pf);
      check_all(); advance();

      // watchdog trips after WDOG-1 stalled cycles
      step(4'd0, 12'd0, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < WDOG - 1; i++) step(4'b0100, 12'o0300, 1'b0, 32'd0, 1'b0);
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      chk("wdog_trip", 32'(bus.stall_timeout), 32'd1);
      check_all(); advance();
      step(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      chk("wdog_sticky", 32'(bus.stall_timeout), 32'd1);

      // interrupted runs never trip
      step(4'd0, 12'd0, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < WDOG - 2; i++) step(4'b1000, 12'o4000, 1'b0, 32'd0, 1'b0);
      step(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < WDOG - 2; i++) step(4'b1000, 12'o4000, 1'b0, 32'd0, 1'b0);
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      chk("wdog_no_trip", 32'(bus.stall_timeout), 32'd0);
      check_all(); advance();

      // reset during flush
      step(4'b0001, 12'o0001, 1'b1, 32'hDEADBEEF, 1'b0);
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b1);
      chk("rstflush_in_flush", 32'(bus.flush), 32'd1);
      check_all(); advance();
      drive(4'd0, 12'd0, 1'b0, 32'd0, 1'b0);
      chk("rstflush_flush", 32'(bus.flush), 32'd0);
      chk("rstflush_pc", bus.new_pc, 32'd0);
      chk("rstflush_pstall", bus.perf_stall_cnt, 32'd0);
      chk("rstflush_pflush", bus.perf_flush_cnt, 32'd0);
      check_all(); advance();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         step(4'($urandom_range(0, 15) & $urandom_range(0, 15)), 12'($urandom),
              ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 99) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
